// File: rtl/layer_pkg.sv
// Shared opcodes, frame lengths and parser state encoding for the layer
// command decoder.
package layer_pkg;

  localparam logic [7:0] CMD_CONF = 8'h2A;
  localparam logic [7:0] CMD_DATA = 8'h2C;

  localparam int CONF_LEN = 6;
  localparam int DATA_LEN = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONF    = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } parse_state_t;

  // Byte 0 of a word lands in bits 31:24, so lane selection runs MSB-first.
  function automatic logic [3:0] lane_of(input logic [1:0] sel);
    return 4'b1000 >> sel;
  endfunction

endpackage

// File: rtl/layer_cmd_parse.sv
// Byte-stream command decoder: turns SPI bytes into pixel RAM writes and
// owns the WS281x bit-timing registers of one layer.
module layer_cmd_parse
  import layer_pkg::*;
#(
  parameter logic [7:0]  T0H_DEF = 8'd18,
  parameter logic [7:0]  T0L_DEF = 8'd40,
  parameter logic [7:0]  T1H_DEF = 8'd35,
  parameter logic [7:0]  T1L_DEF = 8'd30,
  parameter logic [15:0] RST_DEF = 16'd2500
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        byte_rdy_in,
  input  logic [7:0]  byte_data_in,
  input  logic        frame_end_in,
  output logic        wr_en_out,
  output logic [5:0]  wr_addr_out,
  output logic [7:0]  wr_data_out,
  output logic [3:0]  wr_byte_en_out,
  output logic        wr_done_out,
  output logic [7:0]  t0h_cnt_out,
  output logic [7:0]  t0l_cnt_out,
  output logic [7:0]  t1h_cnt_out,
  output logic [7:0]  t1l_cnt_out,
  output logic [15:0] rst_cnt_out
);

  parse_state_t state_q, state_d;
  logic [8:0]   idx_q, idx_d;
  logic [2:0]   cfg_cnt_q, cfg_cnt_d;
  logic [7:0]   sh_t0h_q, sh_t0h_d;
  logic [7:0]   sh_t0l_q, sh_t0l_d;
  logic [7:0]   sh_t1h_q, sh_t1h_d;
  logic [7:0]   sh_t1l_q, sh_t1l_d;
  logic [7:0]   sh_rsth_q, sh_rsth_d;
  logic         done_pend_q, done_pend_d;

  logic         wr_en_q, wr_en_d;
  logic [5:0]   wr_addr_q, wr_addr_d;
  logic [7:0]   wr_data_q, wr_data_d;
  logic [3:0]   wr_be_q, wr_be_d;
  logic         wr_done_q, wr_done_d;
  logic [7:0]   t0h_q, t0h_d;
  logic [7:0]   t0l_q, t0l_d;
  logic [7:0]   t1h_q, t1h_d;
  logic [7:0]   t1l_q, t1l_d;
  logic [15:0]  rst_cnt_q, rst_cnt_d;

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      idx_q       <= 9'd0;
      cfg_cnt_q   <= 3'd0;
      sh_t0h_q    <= 8'd0;
      sh_t0l_q    <= 8'd0;
      sh_t1h_q    <= 8'd0;
      sh_t1l_q    <= 8'd0;
      sh_rsth_q   <= 8'd0;
      done_pend_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'd0;
      wr_be_q     <= 4'd0;
      wr_done_q   <= 1'b0;
      t0h_q       <= T0H_DEF;
      t0l_q       <= T0L_DEF;
      t1h_q       <= T1H_DEF;
      t1l_q       <= T1L_DEF;
      rst_cnt_q   <= RST_DEF;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cfg_cnt_q   <= cfg_cnt_d;
      sh_t0h_q    <= sh_t0h_d;
      sh_t0l_q    <= sh_t0l_d;
      sh_t1h_q    <= sh_t1h_d;
      sh_t1l_q    <= sh_t1l_d;
      sh_rsth_q   <= sh_rsth_d;
      done_pend_q <= done_pend_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_be_q     <= wr_be_d;
      wr_done_q   <= wr_done_d;
      t0h_q       <= t0h_d;
      t0l_q       <= t0l_d;
      t1h_q       <= t1h_d;
      t1l_q       <= t1l_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  // Next-state: byte handling first, then frame-end closes the frame.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cfg_cnt_d   = cfg_cnt_q;
    sh_t0h_d    = sh_t0h_q;
    sh_t0l_d    = sh_t0l_q;
    sh_t1h_d    = sh_t1h_q;
    sh_t1l_d    = sh_t1l_q;
    sh_rsth_d   = sh_rsth_q;
    done_pend_d = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_be_d     = 4'd0;
    wr_done_d   = done_pend_q;
    t0h_d       = t0h_q;
    t0l_d       = t0l_q;
    t1h_d       = t1h_q;
    t1l_d       = t1l_q;
    rst_cnt_d   = rst_cnt_q;

    if (byte_rdy_in) begin
      case (state_q)
        IDLE: begin
          if (byte_data_in == CMD_CONF) begin
            state_d   = CONF;
            cfg_cnt_d = 3'd0;
          end else if (byte_data_in == CMD_DATA) begin
            state_d = DATA;
            idx_d   = 9'd0;
          end else begin
            state_d = DISCARD;
          end
        end
        CONF: begin
          if (cfg_cnt_q == 3'(CONF_LEN - 1)) begin
            // Commit all timing registers at once; partial frames never get here.
            t0h_d     = sh_t0h_q;
            t0l_d     = sh_t0l_q;
            t1h_d     = sh_t1h_q;
            t1l_d     = sh_t1l_q;
            rst_cnt_d = {sh_rsth_q, byte_data_in};
            cfg_cnt_d = 3'd0;
            state_d   = DISCARD;
          end else begin
            cfg_cnt_d = cfg_cnt_q + 3'd1;
            case (cfg_cnt_q)
              3'd0:    sh_t0h_d  = byte_data_in;
              3'd1:    sh_t0l_d  = byte_data_in;
              3'd2:    sh_t1h_d  = byte_data_in;
              3'd3:    sh_t1l_d  = byte_data_in;
              3'd4:    sh_rsth_d = byte_data_in;
              default: sh_rsth_d = sh_rsth_q;
            endcase
          end
        end
        DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[7:2];
          wr_data_d = byte_data_in;
          wr_be_d   = lane_of(idx_q[1:0]);
          idx_d     = idx_q + 9'd1;
          if (idx_q == 9'(DATA_LEN - 1)) begin
            done_pend_d = 1'b1;
            state_d     = DISCARD;
          end else begin
            done_pend_d = 1'b0;
          end
        end
        DISCARD: begin
          state_d = DISCARD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (frame_end_in) begin
      state_d = IDLE;
      if (state_q == DATA) begin
        // A byte in this same cycle writes next cycle, so done must wait one more.
        if (byte_rdy_in) begin
          done_pend_d = 1'b1;
        end else if (idx_q != 9'd0) begin
          wr_done_d = 1'b1;
        end else begin
          wr_done_d = done_pend_q;
        end
      end else begin
        wr_done_d = done_pend_q;
      end
    end else begin
      wr_done_d = done_pend_q;
    end
  end

  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign wr_byte_en_out = wr_be_q;
  assign wr_done_out    = wr_done_q;
  assign t0h_cnt_out    = t0h_q;
  assign t0l_cnt_out    = t0l_q;
  assign t1h_cnt_out    = t1h_q;
  assign t1l_cnt_out    = t1l_q;
  assign rst_cnt_out    = rst_cnt_q;

endmodule

// File: tb/tb_layer_cmd_parse.sv
// Scoreboard bench for layer_cmd_parse: frame-level reference model queues
// expected writes/done/config events; a monitor compares what the DUT presents.
module tb_layer_cmd_parse;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        byte_rdy_in;
  logic [7:0]  byte_data_in;
  logic        frame_end_in;
  logic        wr_en_out;
  logic [5:0]  wr_addr_out;
  logic [7:0]  wr_data_out;
  logic [3:0]  wr_byte_en_out;
  logic        wr_done_out;
  logic [7:0]  t0h_cnt_out, t0l_cnt_out, t1h_cnt_out, t1l_cnt_out;
  logic [15:0] rst_cnt_out;

  layer_cmd_parse dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_rdy_in(byte_rdy_in),
    .byte_data_in(byte_data_in), .frame_end_in(frame_end_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .wr_byte_en_out(wr_byte_en_out), .wr_done_out(wr_done_out),
    .t0h_cnt_out(t0h_cnt_out), .t0l_cnt_out(t0l_cnt_out),
    .t1h_cnt_out(t1h_cnt_out), .t1l_cnt_out(t1l_cnt_out),
    .rst_cnt_out(rst_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [5:0] addr;
    logic [7:0] data;
    logic [3:0] be;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [47:0] val;
  } cfg_t;

  localparam logic [47:0] CFG_DEF = {8'd18, 8'd40, 8'd35, 8'd30, 16'd2500};

  ev_t         evq[$];
  cfg_t        cfgq[$];
  logic [47:0] cur_cfg = CFG_DEF;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;
  logic [7:0]  fq[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  // Monitor: sample one time unit after the clock edge.
  ev_t mon_e;
  always @(posedge clk_in) begin
    #1;
    if (mon_on) begin
      while (cfgq.size() > 0 && cfgq[0].cyc <= cyc) begin
        cur_cfg = cfgq[0].val;
        void'(cfgq.pop_front());
      end
      chk("timing_regs", {16'd0, t0h_cnt_out, t0l_cnt_out, t1h_cnt_out, t1l_cnt_out, rst_cnt_out},
          {16'd0, cur_cfg});
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        fail_now(evq[0].is_done ? "missed_wr_done" : "missed_wr_en");
        void'(evq.pop_front());
      end
      if (wr_en_out) begin
        if (evq.size() > 0 && !evq[0].is_done && evq[0].cyc == cyc) begin
          mon_e = evq.pop_front();
          chk("write", {46'd0, wr_addr_out, wr_data_out, wr_byte_en_out},
              {46'd0, mon_e.addr, mon_e.data, mon_e.be});
        end else begin
          fail_now("unexpected_wr_en");
        end
      end
      if (wr_done_out) begin
        chk("done_not_with_wr", {63'd0, wr_en_out}, 64'd0);
        if (evq.size() > 0 && evq[0].is_done && evq[0].cyc == cyc) begin
          void'(evq.pop_front());
        end else begin
          fail_now("unexpected_wr_done");
        end
      end
    end
  end

  task automatic push_write(input int a, input int idx, input logic [7:0] d);
    ev_t e;
    e.cyc = a; e.is_done = 1'b0;
    e.addr = 6'(idx / 4);
    e.data = d;
    e.be = 4'(1 << (3 - (idx % 4)));
    evq.push_back(e);
  endtask

  task automatic push_done(input int c);
    ev_t e;
    e.cyc = c; e.is_done = 1'b1; e.addr = 6'd0; e.data = 8'd0; e.be = 4'd0;
    evq.push_back(e);
  endtask

  task automatic do_reset();
    cfg_t c;
    int r;
    @(negedge clk_in);
    rst_in = 1'b1; byte_rdy_in = 1'b0; frame_end_in = 1'b0;
    r = cyc + 1;
    while (evq.size() > 0 && evq[$].cyc >= r) void'(evq.pop_back());
    while (cfgq.size() > 0 && cfgq[$].cyc >= r) void'(cfgq.pop_back());
    c.cyc = r; c.val = CFG_DEF;
    cfgq.push_back(c);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Drive a frame and predict its effect from the command rules.
  task automatic send_frame(input logic [7:0] q[$], input bit end_same, input int max_gap,
                            input bit abort);
    int   n = q.size();
    int   a = 0;
    int   f;
    int   g;
    cfg_t c;
    for (int k = 0; k < n; k++) begin
      g = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
      repeat (g) begin
        @(negedge clk_in); byte_rdy_in = 1'b0; frame_end_in = 1'b0;
      end
      @(negedge clk_in);
      byte_rdy_in = 1'b1; byte_data_in = q[k];
      frame_end_in = (!abort && end_same && k == n - 1);
      a = cyc + 1;
      if (q[0] == 8'h2A && k == 6) begin
        c.cyc = a; c.val = {q[1], q[2], q[3], q[4], q[5], q[6]};
        cfgq.push_back(c);
      end
      if (q[0] == 8'h2C && k >= 1 && k <= 256) begin
        push_write(a, k - 1, q[k]);
        if (k == 256) push_done(a + 1);
      end
    end
    if (abort) begin
      do_reset();
      return;
    end
    if (!end_same) begin
      g = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
      repeat (g) begin
        @(negedge clk_in); byte_rdy_in = 1'b0; frame_end_in = 1'b0;
      end
      @(negedge clk_in);
      byte_rdy_in = 1'b0; frame_end_in = 1'b1;
      f = cyc + 1;
    end else begin
      f = a;
    end
    if (q[0] == 8'h2C && n >= 2 && n <= 256) push_done((a + 1 > f) ? a + 1 : f);
    @(negedge clk_in);
    byte_rdy_in = 1'b0; frame_end_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic build_data(input int len, input bit idx_val);
    fq = {};
    fq.push_back(8'h2C);
    for (int i = 0; i < len; i++) fq.push_back(idx_val ? 8'(i) : 8'($urandom_range(255, 0)));
  endtask

  initial begin
    int kind;
    logic [7:0] op;
    rst_in = 1'b1; byte_rdy_in = 1'b0; byte_data_in = 8'd0; frame_end_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    mon_on = 1'b1;
    @(negedge clk_in);
    chk("reset_wr_outputs", {45'd0, wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out, wr_done_out},
        64'd0);
    chk("reset_timing", {16'd0, t0h_cnt_out, t0l_cnt_out, t1h_cnt_out, t1l_cnt_out, rst_cnt_out},
        {16'd0, CFG_DEF});

    fq = '{8'h2A, 8'h10, 8'h20, 8'h30, 8'h40, 8'h09, 8'hC4};
    send_frame(fq, 1'b0, 0, 1'b0);
    fq = '{8'h2A, 8'h11, 8'h22};
    send_frame(fq, 1'b0, 0, 1'b0);
    build_data(257, 1'b1);
    send_frame(fq, 1'b0, 0, 1'b0);
    build_data(256, 1'b1);
    send_frame(fq, 1'b1, 0, 1'b0);
    fq = '{8'h2C, 8'hAA, 8'hBB, 8'hCC};
    send_frame(fq, 1'b0, 0, 1'b0);
    fq = '{8'h2C, 8'hAA, 8'hBB, 8'hCC};
    send_frame(fq, 1'b1, 0, 1'b0);
    fq = '{8'h2C};
    send_frame(fq, 1'b0, 0, 1'b0);
    fq = '{8'h55, 8'h2C, 8'h01};
    send_frame(fq, 1'b0, 0, 1'b0);
    fq = '{8'h2C, 8'h01};
    send_frame(fq, 1'b0, 0, 1'b0);
    fq = '{8'h2A, 8'h01, 8'h02, 8'h03};
    send_frame(fq, 1'b0, 0, 1'b1);
    build_data(9, 1'b0);
    send_frame(fq, 1'b0, 0, 1'b1);
    fq = '{8'h2A, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_frame(fq, 1'b1, 0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(5, 0);
      case (kind)
        0: begin
          fq = {8'h2A};
          for (int i = 0; i < 6; i++) fq.push_back(8'($urandom_range(255, 0)));
        end
        1: begin
          fq = {8'h2A};
          for (int i = 0; i < $urandom_range(5, 0); i++) fq.push_back(8'($urandom_range(255, 0)));
        end
        2: build_data($urandom_range(40, 1), 1'b0);
        3: build_data($urandom_range(257, 256), 1'b0);
        4: begin
          op = 8'($urandom_range(255, 0));
          if (op == 8'h2A || op == 8'h2C) op = 8'h00;
          fq = {op, 8'h2C, 8'h2A, 8'($urandom_range(255, 0))};
        end
        default: build_data($urandom_range(30, 1), 1'b0);
      endcase
      send_frame(fq, 1'($urandom_range(1, 0)), $urandom_range(2, 0), (kind == 5));
    end

    repeat (10) @(negedge clk_in);
    chk("events_left", 64'(evq.size()), 64'd0);
    chk("cfg_events_left", 64'(cfgq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_cmd_parse.md
# layer_cmd_parse

Command decoder that sits directly upstream of the layer output stage. It takes the byte stream delivered by the SPI slave and turns it into the write port that stage consumes: `wr_en`/`wr_addr`/`wr_data`/`wr_byte_en`/`wr_done` into the 64×32 pixel RAM. It also owns the WS281x bit-timing registers (`t0h/t0l/t1h/t1l/rst_cnt`) that drive the code generator. One instance per layer.

## Interface
Parameters:
- `T0H_DEF`, 8'd18: reset value of `t0h_cnt_out` (clocks)
- `T0L_DEF`, 8'd40: reset value of `t0l_cnt_out`
- `T1H_DEF`, 8'd35: reset value of `t1h_cnt_out`
- `T1L_DEF`, 8'd30: reset value of `t1l_cnt_out`
- `RST_DEF`, 16'd2500: reset value of `rst_cnt_out`

Ports:
- `clk_in`  in  1  single clock
- `rst_in`  in  1  synchronous, active-high reset
- `byte_rdy_in`  in  1  one-cycle strobe, `byte_data_in` valid
- `byte_data_in`  in  8  received byte
- `frame_end_in`  in  1  one-cycle strobe, chip-select released
- `wr_en_out`  out  1  RAM write strobe
- `wr_addr_out`  out  6  RAM word address
- `wr_data_out`  out  8  byte to write (replicated on all lanes downstream)
- `wr_byte_en_out`  out  4  one-hot byte lane
- `wr_done_out`  out  1  one-cycle pulse: frame data complete
- `t0h_cnt_out`, `t0l_cnt_out`, `t1h_cnt_out`, `t1l_cnt_out`  out  8  timing counts
- `rst_cnt_out`  out  16  reset-gap count

## Operation
- States: `IDLE` (expect opcode), `CONF`, `DATA`, `DISCARD`.
- `IDLE`, byte accepted:
  - 0x2A → `CONF`
  - 0x2C → `DATA`, byte index cleared
  - any other value → `DISCARD`
- `CONF`:
  - Six bytes are shadowed in order: t0h, t0l, t1h, t1l, rst[15:8], rst[7:0].
  - On the 6th byte all five outputs update together in one cycle, then → `DISCARD`.
  - Partial config is never committed.
- `DATA`:
  - 9-bit index i (0..256). Byte i writes `wr_addr = i[7:2]` with lane `wr_byte_en = 4'b1000 >> i[1:0]`, so byte 0 lands in bits 31:24.
  - At i = 255 the write is issued, `wr_done` is scheduled, and the state → `DISCARD`.
- `DISCARD`: bytes are ignored.
- `frame_end_in` forces `IDLE` from any state.
  - In `DATA` with i ≥ 1 it schedules `wr_done`.
  - In `DATA` with i = 0 it produces no `wr_done`.
- `byte_rdy_in` and `frame_end_in` in the same cycle: the byte is processed first, then the frame closes. A 256th byte plus frame end gives exactly one `wr_done`.
- Reset mid-operation: return to `IDLE`, timing outputs go to defaults, any pending `wr_done` is cancelled.

## Timing
- All outputs are registered.
- Reset values: `wr_en/wr_byte_en/wr_addr/wr_data/wr_done` = 0; timing outputs = `*_DEF`.
- Latency:
  - `wr_en` is high exactly 1 cycle after the accepting `byte_rdy_in`, for 1 cycle, with addr/data/lane valid in that same cycle.
  - `wr_done` is high 1 cycle after the last `wr_en`, or 1 cycle after `frame_end_in`, whichever comes later; never coincident with `wr_en`.
  - Config outputs change 1 cycle after the 6th config byte.
- Back-to-back `byte_rdy_in` on consecutive cycles must be sustained with no loss.
- `frame_end_in` one cycle after a byte is legal.

## Structure
- Package `layer_pkg`:
  - opcode constants `CMD_CONF = 8'h2A`, `CMD_DATA = 8'h2C`
  - state enum `parse_state_t`
  - `CONF_LEN = 6`, `DATA_LEN = 256`
- Single module, no sub-module. Lane decode and shadow registers stay inline.

## Test plan
- Reset, then idle: all write outputs are 0; timing outputs = 18/40/35/30/2500.
- Frame 2A 10 20 30 40 09 C4 + end → one cycle later t0h=0x10, t0l=0x20, t1h=0x30, t1l=0x40, rst=0x09C4. Frame 2A 11 22 + end → outputs unchanged.
- Frame 2C followed by 256 bytes (value = index), back-to-back:
  - 256 `wr_en` pulses
  - byte 5 → addr 1, lane 4'b0100, data 0x05
  - single `wr_done` 1 cycle after the last write
  - a 257th byte before frame end → no write
- Frame 2C AA BB CC + end → writes addr 0 lanes 1000/0100/0010; `wr_done` 1 cycle after the later of the last `wr_en` and `frame_end_in`. Frame 2C + end → no `wr_done`.
- Unknown opcode 0x55 followed by 0x2C 0x01 → no writes. The next frame 2C 01 writes normally.
- `rst_in` asserted after 3 config bytes, or mid-DATA → `IDLE`, defaults restored, no `wr_done`; the following frame decodes correctly.
